// File: rtl/hamming_decode_stream.sv
// hamming_decode_stream: two-stage streaming SECDED decoder with valid/ready
// handshake on both sides and saturating corrected/uncorrectable word counters.
module hamming_decode_stream #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16,
    localparam int ADDR_WIDTH  = $clog2(DATA_WIDTH + $clog2(DATA_WIDTH + $clog2(DATA_WIDTH + 1) + 1) + 1),
    localparam int CODED_WIDTH = 2 ** ADDR_WIDTH
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic [CODED_WIDTH-1:0] data_in_i,
    input  logic                   valid_in_i,
    output logic                   ready_o,
    output logic [DATA_WIDTH-1:0]  data_out_o,
    output logic                   valid_out_o,
    input  logic                   ready_i,
    output logic                   err_single_o,
    output logic                   err_double_o,
    output logic [ADDR_WIDTH-1:0]  err_pos_o,
    input  logic                   cnt_clear_i,
    output logic [CNT_WIDTH-1:0]   single_cnt_o,
    output logic [CNT_WIDTH-1:0]   double_cnt_o
);
    // Syndromes at or above this value point into the pad region
    localparam logic [ADDR_WIDTH:0] SYN_LIM = (ADDR_WIDTH + 1)'(DATA_WIDTH + ADDR_WIDTH + 1);

    function automatic logic [ADDR_WIDTH-1:0] syndrome(input logic [CODED_WIDTH-1:0] cw);
        logic [ADDR_WIDTH-1:0] s;
        s = '0;
        for (int i = 1; i < CODED_WIDTH; i++)
            if (cw[i]) s ^= ADDR_WIDTH'(i);
        return s;
    endfunction

    function automatic logic [DATA_WIDTH-1:0] extract(input logic [CODED_WIDTH-1:0] cw);
        logic [DATA_WIDTH-1:0] d;
        int j;
        d = '0;
        j = 0;
        for (int i = 3; i < CODED_WIDTH; i++)
            if ((i & (i - 1)) != 0 && j < DATA_WIDTH) begin
                d[j] = cw[i];
                j++;
            end
        return d;
    endfunction

    logic                   s1_valid_q, s1_valid_d;
    logic [CODED_WIDTH-1:0] s1_code_q, s1_code_d;
    logic [ADDR_WIDTH-1:0]  s1_syn_q, s1_syn_d;
    logic                   s1_ovr_q, s1_ovr_d;
    logic                   valid_out_q, valid_out_d;
    logic [DATA_WIDTH-1:0]  data_out_q, data_out_d;
    logic                   err_single_q, err_single_d;
    logic                   err_double_q, err_double_d;
    logic [ADDR_WIDTH-1:0]  err_pos_q, err_pos_d;
    logic [CNT_WIDTH-1:0]   single_cnt_q, single_cnt_d;
    logic [CNT_WIDTH-1:0]   double_cnt_q, double_cnt_d;
    logic                   s2_free, in_fire, s2_load, out_fire, single_hit;
    logic [CODED_WIDTH-1:0] fixed;

    always_comb begin
        out_fire     = valid_out_q && ready_i;
        s2_free      = !valid_out_q || ready_i;
        ready_o      = !s1_valid_q || s2_free;
        in_fire      = ready_o && valid_in_i;
        s2_load      = s2_free && s1_valid_q;
        s1_valid_d   = ready_o ? valid_in_i : s1_valid_q;
        s1_code_d    = in_fire ? data_in_i : s1_code_q;
        s1_syn_d     = in_fire ? syndrome(data_in_i) : s1_syn_q;
        s1_ovr_d     = in_fire ? ^data_in_i : s1_ovr_q;
        single_hit   = s1_ovr_q && ({1'b0, s1_syn_q} < SYN_LIM);
        fixed        = s1_code_q ^ (single_hit ? (CODED_WIDTH'(1) << s1_syn_q) : '0);
        valid_out_d  = s2_free ? s1_valid_q : valid_out_q;
        data_out_d   = s2_load ? extract(fixed) : data_out_q;
        err_single_d = s2_load ? single_hit : err_single_q;
        err_double_d = s2_load ? (s1_ovr_q ? !single_hit : s1_syn_q != '0) : err_double_q;
        err_pos_d    = s2_load ? (single_hit ? s1_syn_q : '0) : err_pos_q;
        // Clear beats a simultaneous increment
        single_cnt_d = cnt_clear_i ? '0 :
                       (out_fire && err_single_q && single_cnt_q != '1) ? single_cnt_q + 1'b1 : single_cnt_q;
        double_cnt_d = cnt_clear_i ? '0 :
                       (out_fire && err_double_q && double_cnt_q != '1) ? double_cnt_q + 1'b1 : double_cnt_q;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            s1_valid_q   <= 1'b0;
            s1_code_q    <= '0;
            s1_syn_q     <= '0;
            s1_ovr_q     <= 1'b0;
            valid_out_q  <= 1'b0;
            data_out_q   <= '0;
            err_single_q <= 1'b0;
            err_double_q <= 1'b0;
            err_pos_q    <= '0;
            single_cnt_q <= '0;
            double_cnt_q <= '0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_code_q    <= s1_code_d;
            s1_syn_q     <= s1_syn_d;
            s1_ovr_q     <= s1_ovr_d;
            valid_out_q  <= valid_out_d;
            data_out_q   <= data_out_d;
            err_single_q <= err_single_d;
            err_double_q <= err_double_d;
            err_pos_q    <= err_pos_d;
            single_cnt_q <= single_cnt_d;
            double_cnt_q <= double_cnt_d;
        end
    end

    assign data_out_o   = data_out_q;
    assign valid_out_o  = valid_out_q;
    assign err_single_o = err_single_q;
    assign err_double_o = err_double_q;
    assign err_pos_o    = err_pos_q;
    assign single_cnt_o = single_cnt_q;
    assign double_cnt_o = double_cnt_q;
endmodule

// File: tb/tb_hamming_decode_stream.sv
// tb_hamming_decode_stream: randomized scoreboard bench for the SECDED stream decoder
// with a behavioural encoder/decoder model and saturating counter model (CNT_WIDTH=4).
module tb_hamming_decode_stream;
    localparam int DW = 32, CNTW = 4, AW = 6, CW = 64, CMAX = 15, LIMIT = DW + AW + 1;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          single;
        logic          dbl;
        logic [AW-1:0] pos;
    } exp_t;

    logic            clk_i = 0, rst_n_i = 0;
    logic [CW-1:0]   data_in_i = '0;
    logic            valid_in_i = 0, ready_i = 1, cnt_clear_i = 0;
    logic            ready_o, valid_out_o, err_single_o, err_double_o;
    logic [DW-1:0]   data_out_o;
    logic [AW-1:0]   err_pos_o;
    logic [CNTW-1:0] single_cnt_o, double_cnt_o;

    exp_t q[$];
    int   checks = 0, passed = 0;
    int   m_single = 0, m_double = 0;
    int   dpos[DW];
    bit   rnd_done;

    always #5 clk_i = ~clk_i;

    hamming_decode_stream #(.DATA_WIDTH(DW), .CNT_WIDTH(CNTW)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .data_in_i(data_in_i), .valid_in_i(valid_in_i),
        .ready_o(ready_o), .data_out_o(data_out_o), .valid_out_o(valid_out_o), .ready_i(ready_i),
        .err_single_o(err_single_o), .err_double_o(err_double_o), .err_pos_o(err_pos_o),
        .cnt_clear_i(cnt_clear_i), .single_cnt_o(single_cnt_o), .double_cnt_o(double_cnt_o)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic fail_now(input string name);
        checks++;
        $display("FAIL %s: bound expired", name);
    endtask

    // Data fills every slot that is neither index 0 nor a power of two, ascending
    function automatic logic [CW-1:0] encode(input logic [DW-1:0] d);
        logic [CW-1:0] cw;
        int syn;
        cw = '0;
        syn = 0;
        for (int j = 0; j < DW; j++) cw[dpos[j]] = d[j];
        for (int i = 1; i < CW; i++) if (cw[i]) syn ^= i;
        for (int k = 0; k < AW; k++) cw[1 << k] = syn[k];
        cw[0] = ^cw;
        return cw;
    endfunction

    function automatic exp_t expect_of(input logic [DW-1:0] d, input logic [CW-1:0] mask);
        exp_t e;
        int idx;
        e = '{data: d, single: 1'b0, dbl: 1'b0, pos: '0};
        idx = 0;
        for (int i = 0; i < CW; i++) if (mask[i]) idx = i;
        if ($countones(mask) == 1) begin
            if (idx < LIMIT) begin
                e.single = 1'b1;
                e.pos = AW'(idx);
            end else e.dbl = 1'b1;
        end else if ($countones(mask) == 2) begin
            e.dbl = 1'b1;
            for (int j = 0; j < DW; j++) if (mask[dpos[j]]) e.data[j] = ~d[j];
        end
        return e;
    endfunction

    task automatic send(input logic [DW-1:0] d, input logic [CW-1:0] mask);
        exp_t e;
        bit done;
        int waited;
        e = expect_of(d, mask);
        data_in_i = encode(d) ^ mask;
        valid_in_i = 1;
        done = 0;
        waited = 0;
        while (!done) begin
            @(negedge clk_i);
            done = ready_o;
            @(posedge clk_i);
            if (done) q.push_back(e);
            #1;
            waited++;
            if (!done && waited > 200) begin
                fail_now("send_accept");
                break;
            end
        end
        valid_in_i = 0;
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 500) begin
            @(posedge clk_i);
            n++;
        end
        #1;
        if (n >= 500) fail_now("drain");
        @(posedge clk_i);
        #1;
    endtask

    task automatic pulse_clear();
        @(posedge clk_i);
        #1 cnt_clear_i = 1;
        @(posedge clk_i);
        #1 cnt_clear_i = 0;
    endtask

    // Monitor: counters every cycle, payload/flags on each output transfer
    initial forever begin
        exp_t e;
        @(negedge clk_i);
        if (rst_n_i) begin
            check("single_cnt", single_cnt_o, m_single);
            check("double_cnt", double_cnt_o, m_double);
            if (valid_out_o && ready_i) begin
                if (q.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_output: got data %h, expected no word", data_out_o);
                end else begin
                    e = q.pop_front();
                    check("data", data_out_o, e.data);
                    check("err_single", err_single_o, e.single);
                    check("err_double", err_double_o, e.dbl);
                    check("err_pos", err_pos_o, e.pos);
                    if (e.single && m_single < CMAX) m_single++;
                    if (e.dbl && m_double < CMAX) m_double++;
                end
            end
            if (cnt_clear_i) begin
                m_single = 0;
                m_double = 0;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        bit saw_low;
        int j = 0;
        for (int i = 3; i < CW; i++)
            if ((i & (i - 1)) != 0 && j < DW) begin
                dpos[j] = i;
                j++;
            end
        #12;
        check("rst_valid_out", valid_out_o, 0);
        check("rst_ready", ready_o, 1);
        check("rst_err_pos", err_pos_o, 0);
        check("rst_single_cnt", single_cnt_o, 0);
        @(posedge clk_i);
        #1 rst_n_i = 1;

        // clean word and latency
        send(32'hDEADBEEF, '0);
        check("latency_early", valid_out_o, 0);
        @(posedge clk_i);
        #1;
        check("latency_valid", valid_out_o, 1);
        check("latency_data", data_out_o, 32'hDEADBEEF);
        drain();

        // directed single / double / pad errors
        send(32'hDEADBEEF, 64'd1 << 5);
        send(32'hDEADBEEF, 64'd1);
        send(32'hDEADBEEF, (64'd1 << 3) | (64'd1 << 9));
        drain();
        check("directed_single_cnt", single_cnt_o, 2);
        check("directed_double_cnt", double_cnt_o, 1);
        send(32'h0F0F1234, 64'd1 << 45);
        drain();

        // backpressure: 4 back-to-back words, output stalled 5 cycles
        saw_low = 0;
        fork
            begin
                ready_i = 0;
                repeat (5) begin
                    @(negedge clk_i);
                    if (!ready_o) saw_low = 1;
                end
                @(posedge clk_i);
                #1 ready_i = 1;
            end
            for (int k = 0; k < 4; k++) send($urandom, (k == 1) ? 64'd1 << 17 : '0);
        join
        drain();
        check("bp_ready_low", saw_low, 1);

        // randomized traffic with random backpressure and occasional clears
        rnd_done = 0;
        fork
            while (!rnd_done) begin
                @(posedge clk_i);
                #1;
                ready_i = ($urandom % 4) != 0;
                cnt_clear_i = ($urandom % 60) == 0;
            end
            begin
                for (int k = 0; k < 300; k++) begin
                    logic [CW-1:0] mask;
                    int a, b, n;
                    n = $urandom % 3;
                    a = $urandom % CW;
                    b = (a + 1 + $urandom % (CW - 1)) % CW;
                    mask = (n == 0) ? '0 : (n == 1) ? (64'd1 << a) : ((64'd1 << a) | (64'd1 << b));
                    send($urandom, mask);
                    repeat ($urandom % 3) @(posedge clk_i);
                    #1;
                end
                rnd_done = 1;
            end
        join
        @(posedge clk_i);
        #1;
        ready_i = 1;
        cnt_clear_i = 0;
        drain();

        // saturation at 15 and clear winning over an increment
        pulse_clear();
        for (int k = 0; k < 17; k++) send($urandom, 64'd1 << (1 + $urandom % 38));
        drain();
        check("sat_single_cnt", single_cnt_o, CMAX);
        ready_i = 0;
        send($urandom, 64'd1 << 7);
        begin
            int n = 0;
            while (!valid_out_o && n < 20) begin
                @(negedge clk_i);
                n++;
            end
            if (n >= 20) fail_now("sat_wait_valid");
        end
        @(posedge clk_i);
        #1;
        ready_i = 1;
        cnt_clear_i = 1;
        @(posedge clk_i);
        #1 cnt_clear_i = 0;
        check("clear_beats_inc", single_cnt_o, 0);
        drain();

        // reset mid-stream with both stages full
        send($urandom, 64'd1 << 12);
        send($urandom, (64'd1 << 2) | (64'd1 << 30));
        drain();
        ready_i = 0;
        send($urandom, 64'd1 << 4);
        send($urandom, '0);
        @(posedge clk_i);
        #2 rst_n_i = 0;
        #1;
        check("mid_rst_valid_out", valid_out_o, 0);
        check("mid_rst_err_single", err_single_o, 0);
        check("mid_rst_err_double", err_double_o, 0);
        check("mid_rst_err_pos", err_pos_o, 0);
        check("mid_rst_single_cnt", single_cnt_o, 0);
        check("mid_rst_double_cnt", double_cnt_o, 0);
        q.delete();
        m_single = 0;
        m_double = 0;
        @(posedge clk_i);
        #1 rst_n_i = 1;
        check("post_rst_ready", ready_o, 1);
        ready_i = 1;
        send(32'h12345678, 64'd1 << 20);
        drain();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
